// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// Latches one operation, captures the ALU result, pulses the owner's done.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             req1_done,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;

  // rst_n gates the grants so ready stays low while reset is held
  assign w_idle = rst_n && (r_state == IDLE);
  assign w_gnt0 = w_idle && req0_valid
               && (!req1_valid || !r_ptr);
  assign w_gnt1 = w_idle && req1_valid
               && (!req0_valid || r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          unique case (1'b1)
            w_gnt0: begin
              r_op    <= req0_op;
              r_a     <= req0_a;
              r_b     <= req0_b;
              r_owner <= 1'b0;
              r_ptr   <= 1'b1;
              r_state <= EXEC;
            end
            w_gnt1: begin
              r_op    <= req1_op;
              r_a     <= req1_a;
              r_b     <= req1_b;
              r_owner <= 1'b1;
              r_ptr   <= 1'b0;
              r_state <= EXEC;
            end
            default: r_state <= IDLE;
          endcase
        end
        EXEC: begin
          r_res   <= alu_result;
          r_zero  <= alu_zero;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign req0_done  = (r_state == RESP) && !r_owner;
  assign req1_done  = (r_state == RESP) && r_owner;
  assign busy       = (r_state == EXEC)
                   || (r_state == RESP);
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_result = r_res;
  assign rsp_zero   = r_zero;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Clocking: the block SHALL use one clock, clk, with all state updated on its rising edge.
REQ-003 Reset: rst_n SHALL be asynchronous and active-low.
REQ-004 Ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  3  requester 0 ALU opcode (000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor).
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_ready  out  1  requester 0 handshake accept.
- req0_done  out  1  requester 0 result valid, one-cycle pulse.
- req1_valid, req1_op, req1_a, req1_b, req1_ready, req1_done: same as requester 0, for requester 1.
- alu_op  out  3  opcode to the shared ALU.
- alu_a, alu_b  out  WIDTH  operands to the shared ALU.
- alu_result  in  WIDTH  ALU result, combinational from alu_op/alu_a/alu_b.
- alu_zero  in  1  ALU zero flag.
- rsp_result  out  WIDTH  registered result of the last operation.
- rsp_zero  out  1  registered zero flag of the last operation.
- busy  out  1  high in EXEC or RESP.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-006 In IDLE with no valid requests, the FSM SHALL stay in IDLE and all ready and done outputs SHALL be 0.
REQ-007 In IDLE with at least one valid request, the block SHALL select one requester and assert its reqN_ready combinationally in that cycle. The other ready SHALL be 0.
REQ-008 A handshake SHALL occur when reqN_valid and reqN_ready are both high at a clock edge. On that edge the block SHALL latch reqN_op/a/b into internal registers, record the owner N, and go to EXEC.
REQ-009 Selection SHALL be round-robin using a 1-bit priority pointer:
- When only one request is valid, that requester SHALL win.
- When both are valid, the requester named by the pointer SHALL win.
REQ-010 At each handshake the pointer SHALL be set to the requester that did not win.
REQ-011 alu_op, alu_a and alu_b SHALL always be driven from the latched registers. They SHALL hold their values in IDLE and RESP.
REQ-012 In EXEC, at the clock edge, the block SHALL capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
REQ-013 In RESP, the block SHALL assert reqN_done for exactly one cycle for the recorded owner only, then return to IDLE.
REQ-014 rsp_result and rsp_zero SHALL be valid while done is high. They SHALL hold until the next EXEC capture.
REQ-015 Timing SHALL be fixed:
- Latency: done high 2 cycles after the handshake edge.
- Throughput: at most one operation every 3 cycles.
- Minimum spacing between a done and the next ready: 1 cycle (ready in IDLE the cycle after RESP).
REQ-016 While busy, both ready outputs SHALL be 0 and requester inputs SHALL be ignored.
REQ-017 Operand or valid changes during EXEC or RESP SHALL NOT affect the result in flight.
REQ-018 A requester that drops valid before a handshake SHALL leave no trace: no latch and no pointer change.
REQ-019 A requester that keeps valid high through its own done SHALL be treated as a new request in the following IDLE cycle.
REQ-020 busy SHALL be 1 exactly when the FSM is in EXEC or RESP.
REQ-021 The block SHALL perform no arithmetic itself. Results SHALL be passed through bit-exact at WIDTH bits.

Reset
REQ-022 While rst_n is 0, the block SHALL force the following, independent of clk:
- FSM state to IDLE.
- Pointer and owner to 0.
- Latched op/a/b, and therefore alu_op/alu_a/alu_b, to 0.
- rsp_result and rsp_zero to 0.
- All ready, done and busy outputs to 0.
REQ-023 Reset asserted during EXEC or RESP SHALL abort the transaction. No done SHALL be issued for it after reset is released.
REQ-024 The first cycle after reset release SHALL be IDLE, with requester 0 preferred on a tie.

Verification
REQ-025 Single request: req0 add a=5, b=7 -> req0_ready high in cycle 0, req0_done high in cycle 2 with rsp_result=12 and rsp_zero=0, req1_done stays 0.
REQ-026 Tie after reset: both valid, req0 sub 9-9 and req1 or 0x0F|0xF0 -> req0 served first (result 0, rsp_zero=1); req1 served next (result 0xFF). Ready pulses are 3 cycles apart.
REQ-027 Round-robin fairness: both valid continuously for 6 grants -> grants alternate 0,1,0,1,0,1 and no requester wins twice in a row.
REQ-028 Operand stability: req1 sll a=1, b=4 granted, then req1_a changed to 0xFFFF during EXEC -> rsp_result=16.
REQ-029 Reset mid-operation: rst_n pulled low in EXEC -> all outputs 0 immediately, no done after release, and the next tie goes to req0.
REQ-030 Ignored while busy: req1_valid rises during EXEC -> req1_ready stays 0 until IDLE, then req1 is granted.
